icb_acc_bridge: RTL

ICB slave peripheral that fronts a bank of N_ACC accelerator instances sharing one unified SRAM. It bridges 32-bit ICB accesses onto a parametrised-width SRAM word, using read-modify-write for sub-word writes. It holds per-channel control/status registers with start pulses, sticky done and a maskable interrupt. It is the generalised successor of the single-channel, fixed-64-bit ICB/MHSA front end, and sits between the SoC ICB fabric and the accelerator wrappers.

---
 rtl/icb_acc_bridge.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/icb_acc_bridge.sv
// ICB slave bridging 32-bit accesses onto a wide unified SRAM (read-modify-write for
// stores) and exposing per-channel accelerator control/status registers.
module icb_acc_bridge #(
    parameter int USRAM_WIDTH = 64,
    parameter int USRAM_DEPTH = 4096,
    parameter int N_ACC       = 1,
    parameter int CSR_SEL_BIT = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           icb_cmd_valid,
    output logic                           icb_cmd_ready,
    input  logic                           icb_cmd_read,
    input  logic [31:0]                    icb_cmd_addr,
    input  logic [31:0]                    icb_cmd_wdata,
    input  logic [3:0]                     icb_cmd_wmask,
    output logic                           icb_rsp_valid,
    input  logic                           icb_rsp_ready,
    output logic [31:0]                    icb_rsp_rdata,
    output logic                           icb_rsp_err,
    output logic                           usram_en,
    output logic                           usram_we,
    output logic [$clog2(USRAM_DEPTH)-1:0] usram_addr,
    output logic [USRAM_WIDTH-1:0]         usram_wdata,
    input  logic [USRAM_WIDTH-1:0]         usram_rdata,
    output logic [N_ACC-1:0]               acc_start,
    input  logic [N_ACC-1:0]               acc_done,
    output logic [32*N_ACC-1:0]            acc_input_base,
    output logic [32*N_ACC-1:0]            acc_output_base,
    output logic                           irq
);

    localparam int AW = $clog2(USRAM_DEPTH);
    localparam int LB = $clog2(USRAM_WIDTH / 8);
    localparam int NL = USRAM_WIDTH / 32;
    localparam int LW = (NL > 1) ? $clog2(NL) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CSR_RSP  = 3'd1;
    localparam logic [2:0] S_RD_ISSUE = 3'd2;
    localparam logic [2:0] S_RD_CAP   = 3'd3;
    localparam logic [2:0] S_RMW_WR   = 3'd4;
    localparam logic [2:0] S_RSP      = 3'd5;

    logic [2:0]             state_q, state_d;
    logic                   is_read_q, is_read_d;
    logic [AW-1:0]          word_q, word_d;
    logic [LW-1:0]          lane_q, lane_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             wmask_q, wmask_d;
    logic [31:0]            rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [USRAM_WIDTH-1:0] merged_q, merged_d;
    logic [N_ACC-1:0]       busy_q, busy_d;
    logic [N_ACC-1:0]       done_q, done_d;
    logic [N_ACC-1:0]       irq_en_q, irq_en_d;
    logic [N_ACC-1:0]       start_q, start_d;
    logic                   irq_q, irq_d;
    logic [31:0]            in_base_q [N_ACC];
    logic [31:0]            in_base_d [N_ACC];
    logic [31:0]            out_base_q [N_ACC];
    logic [31:0]            out_base_d [N_ACC];

    logic [AW-1:0]          cmd_word;
    logic [LW-1:0]          cmd_lane;
    logic [31:0]            csr_off;
    logic                   addr_bad;
    logic [N_ACC-1:0]       start_req;
    logic [N_ACC-1:0]       start_fire;
    logic [N_ACC-1:0]       w1c;
    logic [31:0]            status_word;
    logic [31:0]            rd_lane;
    logic [USRAM_WIDTH-1:0] rmw_word;
    logic                   base_hit;
    logic [1:0]             unused_addr_lsb;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

    assign unused_addr_lsb = icb_cmd_addr[1:0];
    assign cmd_word  = AW'(icb_cmd_addr >> LB);
    assign cmd_lane  = LW'((icb_cmd_addr >> 2) & 32'(NL - 1));
    assign csr_off   = 32'(icb_cmd_addr[CSR_SEL_BIT-1:2]);
    assign start_req = icb_cmd_wdata[N_ACC-1:0] & {N_ACC{icb_cmd_wmask[0]}};

    // Address bits above the SRAM word index and below the CSR select must be clear.
    always_comb begin
        addr_bad = 1'b0;
        for (int i = LB + AW; i < CSR_SEL_BIT; i++) begin
            addr_bad = addr_bad | icb_cmd_addr[i];
        end
    end

    always_comb begin
        status_word = '0;
        status_word[N_ACC-1:0] = done_q;
        status_word[8 +: N_ACC] = busy_q;
    end

    // Lane extraction and sub-word merge of the word fetched in RD_ISSUE.
    always_comb begin
        rd_lane  = '0;
        rmw_word = usram_rdata;
        for (int l = 0; l < NL; l++) begin
            if (LW'(l) == lane_q) begin
                rd_lane = usram_rdata[l*32 +: 32];
                rmw_word[l*32 +: 32] = byte_merge(usram_rdata[l*32 +: 32], wdata_q, wmask_q);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        is_read_d   = is_read_q;
        word_d      = word_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        merged_d    = merged_q;
        irq_en_d    = irq_en_q;
        in_base_d   = in_base_q;
        out_base_d  = out_base_q;
        start_fire  = '0;
        w1c         = '0;
        base_hit    = 1'b0;
        irq_d       = |(done_q & irq_en_q);

        case (state_q)
            S_IDLE: begin
                if (icb_cmd_valid) begin
                    is_read_d   = icb_cmd_read;
                    word_d      = cmd_word;
                    lane_d      = cmd_lane;
                    wdata_d     = icb_cmd_wdata;
                    wmask_d     = icb_cmd_wmask;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = S_CSR_RSP;
                    if (icb_cmd_addr[CSR_SEL_BIT]) begin
                        if (csr_off == 32'd0) begin
                            if (!icb_cmd_read) begin
                                start_fire = start_req & ~busy_q;
                                rsp_err_d  = |(start_req & busy_q);
                            end
                        end else if (csr_off == 32'd1) begin
                            if (icb_cmd_read)          rsp_rdata_d = status_word;
                            else if (icb_cmd_wmask[0]) w1c = icb_cmd_wdata[N_ACC-1:0];
                        end else if (csr_off == 32'd2) begin
                            if (icb_cmd_read)          rsp_rdata_d = 32'(irq_en_q);
                            else if (icb_cmd_wmask[0]) irq_en_d = icb_cmd_wdata[N_ACC-1:0];
                        end else begin
                            for (int i = 0; i < N_ACC; i++) begin
                                if (csr_off == 32'(4 + 2*i)) begin
                                    base_hit = 1'b1;
                                    if (icb_cmd_read) rsp_rdata_d = in_base_q[i];
                                    else in_base_d[i] = byte_merge(in_base_q[i], icb_cmd_wdata, icb_cmd_wmask);
                                end
                                if (csr_off == 32'(5 + 2*i)) begin
                                    base_hit = 1'b1;
                                    if (icb_cmd_read) rsp_rdata_d = out_base_q[i];
                                    else out_base_d[i] = byte_merge(out_base_q[i], icb_cmd_wdata, icb_cmd_wmask);
                                end
                            end
                            if (!base_hit) rsp_err_d = 1'b1;
                        end
                    end else if (addr_bad || (|busy_q)) begin
                        // The SRAM belongs to the accelerators while any channel runs.
                        rsp_err_d = 1'b1;
                    end else begin
                        state_d = S_RD_ISSUE;
                    end
                end
            end
            S_RD_ISSUE: state_d = S_RD_CAP;
            S_RD_CAP: begin
                if (is_read_q) begin
                    rsp_rdata_d = rd_lane;
                    state_d     = S_RSP;
                end else begin
                    merged_d = rmw_word;
                    state_d  = (wmask_q == 4'd0) ? S_RSP : S_RMW_WR;
                end
            end
            S_RMW_WR: state_d = S_RSP;
            S_CSR_RSP, S_RSP: begin
                if (icb_rsp_ready) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        start_d = start_fire;
        busy_d  = (busy_q & ~acc_done) | start_fire;
        // A done pulse wins over a simultaneous write-1-to-clear.
        done_d  = (done_q & ~w1c) | acc_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            is_read_q   <= 1'b0;
            word_q      <= '0;
            lane_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            merged_q    <= '0;
            busy_q      <= '0;
            done_q      <= '0;
            irq_en_q    <= '0;
            start_q     <= '0;
            irq_q       <= 1'b0;
            for (int i = 0; i < N_ACC; i++) begin
                in_base_q[i]  <= '0;
                out_base_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            is_read_q   <= is_read_d;
            word_q      <= word_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            merged_q    <= merged_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            irq_en_q    <= irq_en_d;
            start_q     <= start_d;
            irq_q       <= irq_d;
            for (int i = 0; i < N_ACC; i++) begin
                in_base_q[i]  <= in_base_d[i];
                out_base_q[i] <= out_base_d[i];
            end
        end
    end

    assign icb_cmd_ready = (state_q == S_IDLE);
    assign icb_rsp_valid = (state_q == S_CSR_RSP) || (state_q == S_RSP);
    assign icb_rsp_rdata = rsp_rdata_q;
    assign icb_rsp_err   = rsp_err_q;
    assign usram_en      = (state_q == S_RD_ISSUE) || (state_q == S_RMW_WR);
    assign usram_we      = (state_q == S_RMW_WR);
    assign usram_addr    = usram_en ? word_q : '0;
    assign usram_wdata   = usram_we ? merged_q : '0;
    assign acc_start     = start_q;
    assign irq           = irq_q;

    for (genvar g = 0; g < N_ACC; g++) begin : g_base
        assign acc_input_base[32*g +: 32]  = in_base_q[g];
        assign acc_output_base[32*g +: 32] = out_base_q[g];
    end

endmodule
